// File: rtl/hazard_unit_if.sv
// D-stage instruction descriptor and hazard-control bundle between the pipeline
// front end and the hazard unit.
interface hazard_unit_if #(
  parameter int CNT_W = 16
);
  logic             d_valid;
  logic [4:0]       d_rs;
  logic [4:0]       d_rt;
  logic             d_uses_rs;
  logic             d_uses_rt;
  logic             d_wr;
  logic [4:0]       d_dst;
  logic             d_load;
  logic             d_store;
  logic             redirect;

  logic             stall;
  logic             flush_fd;
  logic             flush_dx;
  logic             dx_fwdX_rs;
  logic             dx_fwdX_rt;
  logic             dx_fwdM_rs;
  logic             dx_fwdM_rt;
  logic             xm_fwdM_rt;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output d_valid, d_rs, d_rt, d_uses_rs, d_uses_rt, d_wr, d_dst, d_load, d_store, redirect,
    input  stall, flush_fd, flush_dx, dx_fwdX_rs, dx_fwdX_rt, dx_fwdM_rs, dx_fwdM_rt,
           xm_fwdM_rt, stall_count
  );

  modport slave (
    input  d_valid, d_rs, d_rt, d_uses_rs, d_uses_rt, d_wr, d_dst, d_load, d_store, redirect,
    output stall, flush_fd, flush_dx, dx_fwdX_rs, dx_fwdX_rt, dx_fwdM_rs, dx_fwdM_rt,
           xm_fwdM_rt, stall_count
  );
endinterface

// File: rtl/hazard_unit.sv
// Hazard detection and forwarding select for the 5-stage MIPS core, using a
// private shadow of the X (p1) and M (p2) stage destination registers.
module hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  hazard_unit_if.slave bus
);

  logic             vld_p1_q, vld_p1_d;
  logic             wr_p1_q, wr_p1_d;
  logic [4:0]       dst_p1_q, dst_p1_d;
  logic             load_p1_q, load_p1_d;
  logic             pend_p1_q, pend_p1_d;
  logic             vld_p2_q, vld_p2_d;
  logic             wr_p2_q, wr_p2_d;
  logic [4:0]       dst_p2_q, dst_p2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic hzx_rs, hzx_rt, hzm_rs, hzm_rt;
  logic lu, stall, flush_dx, defer_rt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic reg_hit(input logic vld, input logic wr, input logic [4:0] dst,
                                   input logic uses, input logic [4:0] src);
    return bus.d_valid & uses & vld & wr & (dst != 5'd0) & (dst == src);
  endfunction

  always_comb begin
    hzx_rs   = reg_hit(vld_p1_q, wr_p1_q, dst_p1_q, bus.d_uses_rs, bus.d_rs);
    hzx_rt   = reg_hit(vld_p1_q, wr_p1_q, dst_p1_q, bus.d_uses_rt, bus.d_rt);
    hzm_rs   = reg_hit(vld_p2_q, wr_p2_q, dst_p2_q, bus.d_uses_rs, bus.d_rs);
    hzm_rt   = reg_hit(vld_p2_q, wr_p2_q, dst_p2_q, bus.d_uses_rt, bus.d_rt);
    // sw data (rt) is only consumed in M, so a load feeding it never stalls
    lu       = (hzx_rs & load_p1_q) | (hzx_rt & load_p1_q & ~bus.d_store);
    stall    = lu & ~bus.redirect;
    flush_dx = bus.redirect | stall;
    defer_rt = bus.d_store & hzx_rt & load_p1_q;
  end

  always_comb begin
    bus.stall       = stall;
    bus.flush_fd    = bus.redirect;
    bus.flush_dx    = flush_dx;
    bus.dx_fwdX_rs  = hzx_rs & ~load_p1_q & ~flush_dx;
    bus.dx_fwdX_rt  = hzx_rt & ~load_p1_q & ~flush_dx;
    bus.dx_fwdM_rs  = hzm_rs & ~hzx_rs & ~flush_dx;
    bus.dx_fwdM_rt  = hzm_rt & ~hzx_rt & ~flush_dx;
    bus.xm_fwdM_rt  = vld_p1_q & pend_p1_q & ~bus.redirect;
    bus.stall_count = cnt_q;
  end

  always_comb begin
    vld_p2_d  = vld_p1_q & ~bus.redirect;
    wr_p2_d   = wr_p1_q;
    dst_p2_d  = dst_p1_q;
    vld_p1_d  = bus.d_valid & ~bus.redirect & ~stall;
    wr_p1_d   = bus.d_wr;
    dst_p1_d  = bus.d_dst;
    load_p1_d = bus.d_load;
    pend_p1_d = defer_rt;
    cnt_d     = stall ? sat_inc(cnt_q) : cnt_q;
  end

  // ---- control state: slot valids and stall counter ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      cnt_q    <= cnt_d;
    end
  end

  // ---- slot payload: qualified by the valids, so left unreset ----
  always_ff @(posedge clk) begin
    wr_p1_q   <= wr_p1_d;
    dst_p1_q  <= dst_p1_d;
    load_p1_q <= load_p1_d;
    pend_p1_q <= pend_p1_d;
    wr_p2_q   <= wr_p2_d;
    dst_p2_q  <= dst_p2_d;
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios with literal
// expectations plus randomized traffic against an in-flight instruction model.
module tb_hazard_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       d_valid, d_uses_rs, d_uses_rt, d_wr, d_load, d_store, redir;
  logic [4:0] d_rs, d_rt, d_dst;

  hazard_unit_if #(.CNT_W(16)) if16 ();
  hazard_unit_if #(.CNT_W(2))  if2 ();

  hazard_unit #(.CNT_W(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));
  hazard_unit #(.CNT_W(2))  dut2  (.clk(clk), .rst(rst), .bus(if2));

  assign if16.d_valid = d_valid;   assign if2.d_valid = d_valid;
  assign if16.d_rs = d_rs;         assign if2.d_rs = d_rs;
  assign if16.d_rt = d_rt;         assign if2.d_rt = d_rt;
  assign if16.d_uses_rs = d_uses_rs; assign if2.d_uses_rs = d_uses_rs;
  assign if16.d_uses_rt = d_uses_rt; assign if2.d_uses_rt = d_uses_rt;
  assign if16.d_wr = d_wr;         assign if2.d_wr = d_wr;
  assign if16.d_dst = d_dst;       assign if2.d_dst = d_dst;
  assign if16.d_load = d_load;     assign if2.d_load = d_load;
  assign if16.d_store = d_store;   assign if2.d_store = d_store;
  assign if16.redirect = redir;    assign if2.redirect = redir;

  // {stall, flush_fd, flush_dx, fwdX_rs, fwdX_rt, fwdM_rs, fwdM_rt, xm_fwdM_rt}
  logic [7:0] outs16, outs2;
  assign outs16 = {if16.stall, if16.flush_fd, if16.flush_dx, if16.dx_fwdX_rs, if16.dx_fwdX_rt,
                   if16.dx_fwdM_rs, if16.dx_fwdM_rt, if16.xm_fwdM_rt};
  assign outs2  = {if2.stall, if2.flush_fd, if2.flush_dx, if2.dx_fwdX_rs, if2.dx_fwdX_rt,
                   if2.dx_fwdM_rs, if2.dx_fwdM_rt, if2.xm_fwdM_rt};

  int vectors = 0;
  int errs = 0;

  // Reference model: the two instructions ahead of D, youngest first.
  typedef struct packed {
    bit       valid;
    bit       writes;
    bit [4:0] dst;
    bit       is_load;
    bit       deferred;
  } rec_t;
  rec_t infl[2];
  int   m_cnt16, m_cnt2;

  task automatic model_reset();
    infl[0] = '0;
    infl[1] = '0;
    m_cnt16 = 0;
    m_cnt2  = 0;
  endtask

  // Age of the nearest in-flight producer of a source register, -1 if none.
  function automatic int producer(input bit uses, input bit [4:0] r);
    if (!d_valid || !uses || r == 5'd0) return -1;
    for (int a = 0; a < 2; a++)
      if (infl[a].valid && infl[a].writes && infl[a].dst == r) return a;
    return -1;
  endfunction

  function automatic logic [7:0] model_out();
    int  prs, prt;
    bit  lu, st, fdx;
    prs = producer(d_uses_rs, d_rs);
    prt = producer(d_uses_rt, d_rt);
    lu  = (prs == 0 && infl[0].is_load) || (prt == 0 && infl[0].is_load && !d_store);
    st  = lu && !redir;
    fdx = redir || st;
    return {st, redir, fdx,
            !fdx && prs == 0 && !infl[0].is_load,
            !fdx && prt == 0 && !infl[0].is_load,
            !fdx && prs == 1,
            !fdx && prt == 1,
            infl[0].valid && infl[0].deferred && !redir};
  endfunction

  task automatic model_clock();
    logic [7:0] o;
    bit defer;
    o     = model_out();
    defer = d_store && producer(d_uses_rt, d_rt) == 0 && infl[0].is_load;
    if (o[7]) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    infl[1] = redir ? '0 : infl[0];
    if (redir || o[7] || !d_valid) infl[0] = '0;
    else infl[0] = '{valid: 1'b1, writes: d_wr, dst: d_dst, is_load: d_load, deferred: defer};
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit [4:0] rs, input bit [4:0] rt, input bit urs,
                       input bit urt, input bit wr, input bit [4:0] dst, input bit ld,
                       input bit st, input bit rd);
    d_valid = v; d_rs = rs; d_rt = rt; d_uses_rs = urs; d_uses_rt = urt;
    d_wr = wr; d_dst = dst; d_load = ld; d_store = st; redir = rd;
  endtask

  task automatic i_alu(input bit [4:0] rd, input bit [4:0] rs, input bit [4:0] rt);
    drive(1, rs, rt, 1, 1, 1, rd, 0, 0, 0);
  endtask
  task automatic i_lw(input bit [4:0] rt, input bit [4:0] base);
    drive(1, base, rt, 1, 0, 1, rt, 1, 0, 0);
  endtask
  task automatic i_sw(input bit [4:0] rt, input bit [4:0] base);
    drive(1, base, rt, 1, 1, 0, 5'd0, 0, 1, 0);
  endtask
  task automatic i_nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic drain();
    i_nop(); tick(); tick();
  endtask

  task automatic test_reset();
    drive(1, 5'd3, 5'd3, 1, 1, 1, 5'd3, 1, 0, 0);
    model_reset();
    @(negedge clk);
    vectors++;
    if (outs16 !== 8'h00) begin $display("FAIL reset_outs got=%b want=%b", outs16, 8'h00); errs++; end
    vectors++;
    if (if16.stall_count !== 16'd0 || if2.stall_count !== 2'd0) begin
      $display("FAIL reset_count got=%0d/%0d want=0/0", if16.stall_count, if2.stall_count); errs++;
    end
    rst = 1'b0;
    drain();
  endtask

  task automatic test_alu_dist1();
    drain();
    i_alu(5'd3, 5'd1, 5'd2); tick();
    i_alu(5'd4, 5'd3, 5'd5);
    @(negedge clk);
    vectors++;
    if (outs16 !== 8'b0001_0000) begin $display("FAIL alu_dist1 got=%b want=%b", outs16, 8'b0001_0000); errs++; end
    tick();
  endtask

  task automatic test_alu_dist2();
    drain();
    i_alu(5'd3, 5'd1, 5'd2); tick();
    i_nop(); tick();
    i_alu(5'd7, 5'd3, 5'd6);
    @(negedge clk);
    vectors++;
    if (outs16 !== 8'b0000_0100) begin $display("FAIL alu_dist2 got=%b want=%b", outs16, 8'b0000_0100); errs++; end
    tick();
    drain();
    i_alu(5'd3, 5'd1, 5'd2); tick();
    i_alu(5'd3, 5'd1, 5'd2); tick();
    i_alu(5'd7, 5'd3, 5'd6);
    @(negedge clk);
    vectors++;
    if (outs16 !== 8'b0001_0000) begin $display("FAIL alu_x_priority got=%b want=%b", outs16, 8'b0001_0000); errs++; end
    tick();
  endtask

  task automatic test_load_use();
    drain();
    i_lw(5'd5, 5'd1); tick();
    i_alu(5'd6, 5'd5, 5'd7);
    @(negedge clk);
    vectors++;
    if (outs16 !== 8'b1010_0000) begin $display("FAIL load_use_c1 got=%b want=%b", outs16, 8'b1010_0000); errs++; end
    tick();
    @(negedge clk);
    vectors++;
    if (outs16 !== 8'b0000_0100) begin $display("FAIL load_use_c2 got=%b want=%b", outs16, 8'b0000_0100); errs++; end
    vectors++;
    if (if16.stall_count !== 16'd1) begin $display("FAIL load_use_count got=%0d want=1", if16.stall_count); errs++; end
    tick();
  endtask

  task automatic test_load_store();
    drain();
    i_lw(5'd5, 5'd1); tick();
    i_sw(5'd5, 5'd2);
    @(negedge clk);
    vectors++;
    if (outs16 !== 8'b0000_0000) begin $display("FAIL store_data_d got=%b want=%b", outs16, 8'b0000_0000); errs++; end
    tick();
    i_nop();
    @(negedge clk);
    vectors++;
    if (outs16 !== 8'b0000_0001) begin $display("FAIL store_data_xm got=%b want=%b", outs16, 8'b0000_0001); errs++; end
    tick();
    drain();
    i_lw(5'd5, 5'd1); tick();
    i_sw(5'd6, 5'd5);
    @(negedge clk);
    vectors++;
    if (outs16 !== 8'b1010_0000) begin $display("FAIL store_base got=%b want=%b", outs16, 8'b1010_0000); errs++; end
    tick();
    @(negedge clk);
    vectors++;
    if (outs16 !== 8'b0000_0100) begin $display("FAIL store_base_fwd got=%b want=%b", outs16, 8'b0000_0100); errs++; end
    tick();
  endtask

  task automatic test_redirect();
    drain();
    i_lw(5'd5, 5'd1); tick();
    drive(1, 5'd5, 5'd7, 1, 1, 1, 5'd6, 0, 0, 1);
    @(negedge clk);
    vectors++;
    if (outs16 !== 8'b0110_0000) begin $display("FAIL redirect got=%b want=%b", outs16, 8'b0110_0000); errs++; end
    tick();
    i_alu(5'd6, 5'd5, 5'd7);
    @(negedge clk);
    vectors++;
    if (outs16 !== 8'b0000_0000) begin $display("FAIL redirect_after got=%b want=%b", outs16, 8'b0000_0000); errs++; end
    vectors++;
    if (if16.stall_count !== 16'd2) begin $display("FAIL redirect_count got=%0d want=2", if16.stall_count); errs++; end
    tick();
  endtask

  task automatic test_zero_reg();
    drain();
    i_alu(5'd0, 5'd1, 5'd2); tick();
    i_alu(5'd4, 5'd0, 5'd0);
    @(negedge clk);
    vectors++;
    if (outs16 !== 8'b0000_0000) begin $display("FAIL zero_alu got=%b want=%b", outs16, 8'b0000_0000); errs++; end
    tick();
    drain();
    i_lw(5'd0, 5'd1); tick();
    i_alu(5'd4, 5'd0, 5'd0);
    @(negedge clk);
    vectors++;
    if (outs16 !== 8'b0000_0000) begin $display("FAIL zero_load got=%b want=%b", outs16, 8'b0000_0000); errs++; end
    tick();
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    #2;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drain();
    for (int k = 0; k < 4; k++) begin
      i_lw(5'd5, 5'd1); tick();
      i_alu(5'd6, 5'd5, 5'd7); tick();
    end
    i_nop();
    @(negedge clk);
    vectors++;
    if (if2.stall_count !== 2'd3) begin $display("FAIL sat_count2 got=%0d want=3", if2.stall_count); errs++; end
    vectors++;
    if (if16.stall_count !== 16'd4) begin $display("FAIL sat_count16 got=%0d want=4", if16.stall_count); errs++; end
    tick();
  endtask

  task automatic test_async_reset();
    drain();
    i_lw(5'd5, 5'd1); tick();
    i_alu(5'd6, 5'd5, 5'd7);
    @(negedge clk);
    vectors++;
    if (outs16 !== 8'b1010_0000) begin $display("FAIL async_pre got=%b want=%b", outs16, 8'b1010_0000); errs++; end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (outs16 !== 8'h00 || outs2 !== 8'h00) begin
      $display("FAIL async_outs got=%b/%b want=%b", outs16, outs2, 8'h00); errs++;
    end
    vectors++;
    if (if16.stall_count !== 16'd0 || if2.stall_count !== 2'd0) begin
      $display("FAIL async_count got=%0d/%0d want=0/0", if16.stall_count, if2.stall_count); errs++;
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [7:0] exp;
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 7) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
            1'($urandom), 1'($urandom), $urandom_range(0, 7) == 0);
      @(negedge clk);
      exp = model_out();
      vectors++;
      if (outs16 !== exp || outs2 !== exp) begin
        $display("FAIL rand_outs n=%0d got=%b/%b want=%b", n, outs16, outs2, exp); errs++;
      end
      vectors++;
      if (int'(if16.stall_count) != m_cnt16 || int'(if2.stall_count) != m_cnt2) begin
        $display("FAIL rand_count n=%0d got=%0d/%0d want=%0d/%0d", n, if16.stall_count,
                 if2.stall_count, m_cnt16, m_cnt2); errs++;
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_alu_dist1();
    test_alu_dist2();
    test_load_use();
    test_load_store();
    test_redirect();
    test_zero_reg();
    test_saturation();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
